vga_cursor_overlay: RTL and testbench
=====================================

// Module: vga_cursor_overlay
// PURPOSE
//  Pixel stage directly downstream of the 800x600 VGA timing generator.
//  Consumes x/y/video_on/p_tick/hsync/vsync and a background colour, then overlays a
//  crosshair cursor whose position arrives over a valid/ready handshake.
//  Position updates are double-buffered and take effect only at frame boundaries.
//  Outputs 12-bit RGB plus sync signals delayed so they stay aligned with the colour.
// PARAMETERS
//  CUR_SIZE      16      cursor box edge in pixels (power of 2, 4..64)
//  CURSOR_RGB    12'hF00 cursor colour {R4,G4,B4}
//  H_DISPLAY     800     visible width
//  V_DISPLAY     600     visible height
//  BLINK_FRAMES  36      frames per blink half-period (CURSOR_BLINK_EN only)
// PORTS
//  clk_100MHz  in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  p_tick      in   1   pixel enable from timing generator (1 of every 2 clocks)
//  video_on    in   1   visible-area flag from timing generator
//  x           in   11  current pixel column
//  y           in   11  current pixel row
//  hsync_in    in   1   hsync from timing generator
//  vsync_in    in   1   vsync from timing generator
//  bg_rgb      in   12  background colour for (x,y), same cycle as x/y
//  pos_valid   in   1   new cursor position offered
//  pos_ready   out  1   pending slot empty; transfer occurs when valid&&ready
//  pos_x       in   11  cursor top-left column
//  pos_y       in   11  cursor top-left row
//  rgb         out  12  pixel colour, aligned with hsync_out/vsync_out
//  hsync_out   out  1   hsync_in delayed 2 pixel ticks
//  vsync_out   out  1   vsync_in delayed 2 pixel ticks
// BEHAVIOUR
//  Reset (synchronous, any clock): rgb=0, hsync_out=0, vsync_out=0, pipeline regs=0.
//   Pending slot becomes EMPTY, cursor disabled (cur_en=0), active position (0,0).
//   pos_ready=0 while reset is high and 1 on the first clock after reset.
//   Reset mid-frame drops any pending position. No partial pipeline output may appear.
//  Pending slot FSM: EMPTY -> FULL on pos_valid&&pos_ready (captures pos_x/pos_y).
//   FULL -> EMPTY on commit. pos_ready = (state==EMPTY) && !reset.
//   Holding pos_valid while FULL performs no capture; the source must hold its data.
//  Commit point: p_tick && x==0 && y==V_DISPLAY (first blanking line).
//   If FULL: active pos <= pending, cur_en <= 1, state -> EMPTY.
//   If EMPTY: no change.
//   Capture and commit on the same clock: commit uses the old pending value.
//   A capture can only happen when EMPTY, so no bypass exists; a value accepted
//   at the commit point is committed at the next frame.
//  Pipeline: all stages advance only on clocks with p_tick=1.
//   Stage 1: registers bg_rgb, video_on, syncs and hit flags.
//    Compares use 12-bit zero-extended values:
//    in_box = x>=cx && x<cx+CUR_SIZE && y>=cy && y<cy+CUR_SIZE.
//    dx=x-cx, dy=y-cy (log2(CUR_SIZE) bits).
//    hit = cur_en && in_box && (dx==0 || dx==CUR_SIZE-1 || dy==0 || dy==CUR_SIZE-1
//          || dx==CUR_SIZE/2 || dy==CUR_SIZE/2)   (square outline plus crosshair)
//   Stage 2: rgb <= !video_on_d ? 0 : hit_d ? CURSOR_RGB : bg_rgb_d.
//    Syncs are delayed to match.
//   Latency: exactly 2 pixel ticks (4 clocks) from x/y/bg_rgb/syncs to outputs.
//  Clipping: cursor parts beyond H_DISPLAY/V_DISPLAY are blanked by video_on.
//   pos_x near 2047 must not wrap, which the 12-bit sums guarantee.
//  Active position is stable for the whole visible frame, so there is no tearing.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//   Frame counter increments at every commit point, wraps at BLINK_FRAMES-1, and
//   toggles a blink flag on wrap. hit is additionally gated by blink=1.
//   Reset sets counter=0, blink=1.
//  CURSOR_BLINK_EN undefined: no counter or flag; hit is as above, always visible.
// TESTING
//  1 Reset, no position sent, bg_rgb=12'h0A0 -> every visible rgb=0A0, blanking rgb=0,
//    pos_ready=1.
//  2 Send (100,50) mid-frame -> ready drops to 0; cursor absent this frame.
//    Next frame: rgb=F00 at (100,50),(115,50),(108,57); rgb=0A0 at (101,51);
//    ready returns to 1 after the commit point.
//  3 Alignment: hsync_in/vsync_in edges appear on hsync_out/vsync_out exactly 4 clocks later.
//    rgb for x=0 appears 4 clocks after x=0 is presented.
//  4 Send (790,595) -> only (790..799, 595..599) drawn.
//    Send (2040,0) -> nothing drawn, no wrap to column 0.
//  5 Two sends back-to-back -> second held (ready=0) until commit.
//    First position shows on frame N+1, second on frame N+2.
//    Send exactly at commit clock -> shown one frame later.
//  6 Reset asserted mid-line with pending FULL -> outputs 0 next clock, cursor disabled,
//    pending discarded. With CURSOR_BLINK_EN, BLINK_FRAMES=2: visible 2 frames,
//    hidden 2 frames.

Source files
------------

// File: rtl/vga_cursor_overlay_if.sv
// Cursor-position handshake between the position source and the overlay stage.
// The master offers pos_x/pos_y with pos_valid. The slave accepts them with pos_ready.
interface vga_cursor_overlay_if;
  logic        pos_valid;
  logic        pos_ready;
  logic [10:0] pos_x;
  logic [10:0] pos_y;

  modport master (output pos_valid, output pos_x, output pos_y, input pos_ready);
  modport slave  (input pos_valid, input pos_x, input pos_y, output pos_ready);
endinterface

// File: rtl/vga_cursor_overlay.sv
// Crosshair cursor overlay for the 800x600 VGA pixel stream, with a 2-tick aligned pipeline.
// Optional blinking is enabled by defining CURSOR_BLINK_EN.
module vga_cursor_overlay #(
  parameter int unsigned CUR_SIZE     = 16,
  parameter logic [11:0] CURSOR_RGB   = 12'hF00,
  parameter int unsigned H_DISPLAY    = 800,
  parameter int unsigned V_DISPLAY    = 600,
  parameter int unsigned BLINK_FRAMES = 36
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       p_tick,
  input  logic                       video_on,
  input  logic [10:0]                x,
  input  logic [10:0]                y,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic [11:0]                bg_rgb,
  vga_cursor_overlay_if.slave        pos_if,
  output logic [11:0]                rgb,
  output logic                       hsync_out,
  output logic                       vsync_out
);

  localparam int LG = $clog2(CUR_SIZE);

  if (CUR_SIZE < 4 || CUR_SIZE > 64 || (CUR_SIZE & (CUR_SIZE - 1)) != 0 ||
      H_DISPLAY > 2047 || V_DISPLAY > 2047 || BLINK_FRAMES < 1) begin : g_illegal_params
    $error("vga_cursor_overlay: illegal parameter set");
  end

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e       state_q, state_d;
  logic [10:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [10:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        cur_en_q, cur_en_d;

  logic [11:0] bg_q, bg_d;
  logic        von_q, von_d, hs1_q, hs1_d, vs1_q, vs1_d, hit_q, hit_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d;

  logic          commit, capture, in_box, on_line, blink_gate, hit;
  logic [11:0]   x_w, y_w, cx_w, cy_w;
  logic [LG-1:0] dx, dy;

  // The commit point sits on the first blanking line, so the visible frame never sees a position change.
  assign commit  = p_tick && (x == 11'd0) && (y == 11'(V_DISPLAY));
  assign capture = pos_if.pos_valid && pos_if.pos_ready;
  assign pos_if.pos_ready = (state_q == EMPTY) && !reset;

  // Compare in 12 bits so that a box placed near column 2047 cannot wrap back to column 0.
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign cx_w = {1'b0, cur_x_q};
  assign cy_w = {1'b0, cur_y_q};
  assign dx   = LG'(x_w - cx_w);
  assign dy   = LG'(y_w - cy_w);

  assign in_box = (x_w >= cx_w) && (x_w < cx_w + 12'(CUR_SIZE)) &&
                  (y_w >= cy_w) && (y_w < cy_w + 12'(CUR_SIZE));
  assign on_line = (dx == '0) || (dx == LG'(CUR_SIZE - 1)) || (dx == LG'(CUR_SIZE / 2)) ||
                   (dy == '0) || (dy == LG'(CUR_SIZE - 1)) || (dy == LG'(CUR_SIZE / 2));
  assign hit = cur_en_q && in_box && on_line && blink_gate;

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (commit) begin
      if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blink_d = !blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      fcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_gate = blink_q;
`else
  assign blink_gate = 1'b1;
`endif

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    cur_en_d = cur_en_q;
    if (commit && state_q == FULL) begin
      cur_x_d  = pend_x_q;
      cur_y_d  = pend_y_q;
      cur_en_d = 1'b1;
      state_d  = EMPTY;
    end else if (capture) begin
      pend_x_d = pos_if.pos_x;
      pend_y_d = pos_if.pos_y;
      state_d  = FULL;
    end
  end

  always_comb begin
    bg_d  = bg_q;
    von_d = von_q;
    hs1_d = hs1_q;
    vs1_d = vs1_q;
    hit_d = hit_q;
    rgb_d = rgb_q;
    hs2_d = hs2_q;
    vs2_d = vs2_q;
    if (p_tick) begin
      bg_d  = bg_rgb;
      von_d = video_on;
      hs1_d = hsync_in;
      vs1_d = vsync_in;
      hit_d = hit;
      rgb_d = !von_q ? 12'h000 : (hit_q ? CURSOR_RGB : bg_q);
      hs2_d = hs1_q;
      vs2_d = vs1_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= EMPTY;
      pend_x_q <= '0;
      pend_y_q <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      cur_en_q <= 1'b0;
      bg_q     <= '0;
      von_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      hit_q    <= 1'b0;
      rgb_q    <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      cur_en_q <= cur_en_d;
      bg_q     <= bg_d;
      von_q    <= von_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      hit_q    <= hit_d;
      rgb_q    <= rgb_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Randomised bench for vga_cursor_overlay against a frame-level cursor model.
// It also models blinking when CURSOR_BLINK_EN is defined.
module tb_vga_cursor_overlay;

  localparam int CS = 16;
  localparam int VD = 600;
  localparam logic [11:0] CUR_COL = 12'hF00;
`ifdef CURSOR_BLINK_EN
  localparam int BF = 2;
  localparam bit BLINK_ON = 1'b1;
`else
  localparam int BF = 36;
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0, video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic [11:0] bg_rgb = '0, rgb;
  logic        hsync_out, vsync_out;

  vga_cursor_overlay_if pif ();

  vga_cursor_overlay #(.CUR_SIZE(CS), .CURSOR_RGB(CUR_COL), .H_DISPLAY(800),
                       .V_DISPLAY(VD), .BLINK_FRAMES(BF)) dut (
    .clk_100MHz(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
    .pos_if(pif.slave), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model: one pending slot, an active cursor and a blink phase.
  bit m_full, m_en, m_blink;
  int m_px, m_py, m_cx, m_cy, m_cnt;
  logic [13:0] exp_q[$];
  int src_x[$], src_y[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_rgb(int px, int py, bit von, logic [11:0] bg);
    int dx = px - m_cx;
    int dy = py - m_cy;
    bit box = dx >= 0 && dx < CS && dy >= 0 && dy < CS;
    bit line = dx == 0 || dx == CS - 1 || dx == CS / 2 || dy == 0 || dy == CS - 1 || dy == CS / 2;
    if (!von) return 12'h000;
    if (m_en && m_blink && box && line) return CUR_COL;
    return bg;
  endfunction

  task automatic model_reset();
    m_full = 0; m_en = 0; m_blink = 1;
    m_px = 0; m_py = 0; m_cx = 0; m_cy = 0; m_cnt = 0;
    exp_q.delete();
    exp_q.push_back(14'h0);
  endtask

  // One pixel tick: a clock with p_tick high, then a clock with p_tick low and scrambled inputs.
  task automatic tick(input int px_in, input int py_in, input bit allow_send);
    int px = px_in & 2047;
    int py = py_in & 2047;
    bit von = px < 800 && py < VD;
    bit hs = 1'($urandom);
    bit vs = 1'($urandom);
    logic [11:0] bg = 12'($urandom);
    bit send = allow_send && src_x.size() > 0;
    bit old_full, commit;
    logic [13:0] got_exp;
    @(negedge clk);
    p_tick = 1'b1; x = 11'(px); y = 11'(py); video_on = von;
    hsync_in = hs; vsync_in = vs; bg_rgb = bg;
    pif.pos_valid = send;
    pif.pos_x = send ? 11'(src_x[0]) : 11'($urandom);
    pif.pos_y = send ? 11'(src_y[0]) : 11'($urandom);
    #1 check("pos_ready", 32'(pif.pos_ready), 32'(!m_full));
    exp_q.push_back({ref_rgb(px, py, von, bg), hs, vs});
    old_full = m_full;
    commit = px == 0 && py == VD;
    if (commit && old_full) begin
      m_cx = m_px; m_cy = m_py; m_en = 1; m_full = 0;
    end
    if (send && !old_full) begin
      m_px = src_x.pop_front(); m_py = src_y.pop_front(); m_full = 1;
    end
    if (commit && BLINK_ON) begin
      if (m_cnt == BF - 1) begin m_cnt = 0; m_blink = !m_blink; end
      else m_cnt++;
    end
    @(negedge clk);
    p_tick = 1'b0; pif.pos_valid = 1'b0;
    x = 11'($urandom); y = 11'($urandom); bg_rgb = 12'($urandom);
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); video_on = 1'($urandom);
    got_exp = exp_q.pop_front();
    check("rgb", 32'(rgb), 32'(got_exp[13:2]));
    check("hsync_out", 32'(hsync_out), 32'(got_exp[1]));
    check("vsync_out", 32'(vsync_out), 32'(got_exp[0]));
  endtask

  // A compressed frame: probes on the active and pending outlines, random pixels, then the commit point.
  task automatic frame(input int n_rand, input bit send_only_at_commit);
    int ox[6] = '{0, CS - 1, CS / 2, 1, CS, -1};
    int oy[6] = '{0, 0, CS / 2 - 1, 1, 0, 0};
    bit as = !send_only_at_commit;
    for (int i = 0; i < 6; i++) begin
      tick(m_cx + ox[i], m_cy + oy[i], as);
      tick(m_px + ox[i], m_py + oy[i], as);
    end
    for (int i = 0; i < n_rand; i++) begin
      if ($urandom_range(1, 0) == 1)
        tick(m_px + $urandom_range(CS + 3, 0) - 2, m_py + $urandom_range(CS + 3, 0) - 2, as);
      else
        tick($urandom_range(1055, 0), $urandom_range(627, 0), as);
    end
    tick(0, VD, 1'b1);
  endtask

  task automatic push_pos(input int px, input int py);
    src_x.push_back(px);
    src_y.push_back(py);
  endtask

  initial begin
    pif.pos_valid = 1'b0; pif.pos_x = '0; pif.pos_y = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(pif.pos_ready), 32'd0);
    check("rgb_after_reset", 32'(rgb), 32'h0);
    check("hsync_after_reset", 32'(hsync_out), 32'd0);
    check("vsync_after_reset", 32'(vsync_out), 32'd0);
    reset = 1'b0;

    frame(30, 1'b0);
    push_pos(100, 50);
    repeat (2) frame(30, 1'b0);
    push_pos(790, 595);
    repeat (2) frame(30, 1'b0);
    push_pos(2040, 0);
    repeat (2) frame(30, 1'b0);
    push_pos(300, 200);
    push_pos(400, 300);
    repeat (3) frame(30, 1'b0);
    push_pos(500, 100);
    repeat (3) frame(20, 1'b1);
    for (int f = 0; f < 5; f++) begin
      push_pos($urandom_range(2047, 0), $urandom_range(700, 0));
      frame(30, 1'b0);
    end

    // Reset mid-line while the pending slot is full.
    push_pos(200, 150);
    for (int i = 0; i < 5; i++) tick(100 + i, 20, 1'b1);
    check("slot_full_before_reset", 32'(pif.pos_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1; p_tick = 1'($urandom);
    #1 check("ready_in_reset", 32'(pif.pos_ready), 32'd0);
    @(negedge clk);
    check("rgb_after_reset", 32'(rgb), 32'h0);
    check("hsync_after_reset", 32'(hsync_out), 32'd0);
    check("vsync_after_reset", 32'(vsync_out), 32'd0);
    reset = 1'b0;
    model_reset();
    src_x.delete();
    src_y.delete();
    repeat (2) frame(20, 1'b0);
    push_pos(64, 32);
    repeat (5) frame(25, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
